serial_multi_adder: RTL and testbench
=====================================

Name: serial_multi_adder

Overview:
- Bit-serial adder that sums N_OPS operands, each WORD_BITS wide, fed LSB-first at one bit per operand per cycle.
- Carry state is a multi-bit register, clog2(N_OPS) wide, and is cleared at every word boundary.
- After the last input bit it flushes the carry as extra result bits, so each result is WORD_BITS+CW bits long.
- Successor to the fixed 4-input serial adder. Adds operand count and word length as parameters, word framing, a valid/ready handshake, a registered output and reset.

Parameters:
- N_OPS, 4, number of operand bit-streams (must be >= 2).
- WORD_BITS, 8, bits per operand word (must be >= 1).
- CW, clog2(N_OPS), derived and not overridable. Carry register width and number of flush bits.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- clear  input  1  synchronous abort of the current word (see below).
- in_valid  input  1  in_bits holds a valid bit slice.
- in_ready  output  1  block accepts a slice this cycle.
- in_bits  input  N_OPS  bit k is the current bit of operand k, LSB-first.
- out_valid  output  1  out_bit is a valid result bit.
- out_bit  output  1  current result bit, LSB-first.
- out_last  output  1  marks the final (MSB) bit of a result, qualified by out_valid.
- busy  output  1  a word is partially accepted or being flushed.

Behaviour:
- State: st in {ACCUM, FLUSH}; carry[CW-1:0]; cnt counting 0..WORD_BITS-1 in ACCUM and 0..CW-1 in FLUSH.
- Reset (reset=1 at an edge): st=ACCUM, carry=0, cnt=0, out_valid=0, out_bit=0, out_last=0. Reset takes priority over clear and over any handshake.
- in_ready = (st==ACCUM). It is combinational from state only and never depends on in_valid.
- Accept happens when in_valid & in_ready.
- ACCUM, on accept:
  - total = popcount(in_bits) + carry, width CW+1.
  - Next cycle: out_bit = total[0], carry = total >> 1, out_valid=1, out_last=0.
  - Latency is exactly 1 cycle from accept to the corresponding out_bit.
- ACCUM, no accept: out_valid=0 on the next cycle; carry and cnt are held. Stalls of any length are legal.
- Word end: on the accept where cnt==WORD_BITS-1, set cnt=0 and st=FLUSH.
- FLUSH, each cycle (no input needed, in_ready=0):
  - out_bit = carry[0], carry = carry >> 1, out_valid=1.
  - out_last=1 when cnt==CW-1; at that point st=ACCUM, cnt=0, carry=0.
  - Flush lasts exactly CW cycles.
- Carry bound: carry never exceeds N_OPS-1, so it never overflows.
- Result: the emitted WORD_BITS+CW bits equal the exact sum of the N_OPS unsigned operands.
- Back-to-back words: the first bit of the next word is accepted in the cycle after the last flush cycle. Per word throughput is WORD_BITS accepted cycles plus CW flush cycles.
- No output backpressure: the consumer must take every out_valid bit.
- busy = (st==FLUSH) | (cnt!=0).
- clear=1 at an edge, without reset: st=ACCUM, carry=0, cnt=0, out_valid=0, out_last=0. Any in-flight word is discarded, and a slice accepted in that same cycle is discarded too. The first slice accepted after clear starts a new word.
- Reset mid-word or mid-flush: same effect as clear. No partial result bits are emitted after the edge.

Test Plan:
- N_OPS=4, WORD_BITS=8, four operands 0xFF, continuous valid -> 10 out bits 0,0,1,1,1,1,1,1,1,1 (0x3FC). out_last set on the 10th bit only; in_ready low for 2 cycles.
- Operands 1,2,3,4 -> out bits 0,1,0,1,0,0,0,0 then flush 0,0 (value 10); out_valid one cycle after each accept.
- Same operands as the first case with in_valid deasserted for 3 random cycles mid-word -> identical bit sequence, out_valid=0 in the cycle after each stall, carry preserved.
- Two back-to-back words (0xFF x4, then 1,2,3,4) -> 0x3FC then 0x00A. The second word's first bit is accepted the cycle after out_last. No carry leaks between words.
- clear asserted after 5 accepted bits of 0xFF x4, then word 1,2,3,4 -> no out_valid the cycle after clear, next result 0x00A.
- reset asserted during flush has the same effect as clear.
- N_OPS=3 (CW=2), operands 0xFF x3 -> 765 = 0x2FD, 10 bits LSB-first: 1,0,1,1,1,1,1,1,0,1.

Source files
------------

// File: rtl/serial_multi_adder.sv
// Bit-serial adder for N_OPS unsigned LSB-first operand streams.
// Each word yields WORD_BITS sum bits followed by CW carry-flush bits.
module serial_multi_adder #(
    parameter int N_OPS     = 4,
    parameter int WORD_BITS = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_OPS-1:0] in_bits,
    output logic             out_valid,
    output logic             out_bit,
    output logic             out_last,
    output logic             busy
);

    localparam int CW   = $clog2(N_OPS);
    localparam int CMAX = (WORD_BITS > CW) ? WORD_BITS : CW;
    localparam int CNTW = (CMAX > 1) ? $clog2(CMAX) : 1;

    localparam logic [0:0] ST_ACCUM = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    logic [0:0]    st_reg, st_next;
    logic [CW-1:0] carry_reg, carry_next;
    logic [CNTW-1:0] cnt_reg, cnt_next;
    logic          out_valid_reg, out_valid_next;
    logic          out_bit_reg, out_bit_next;
    logic          out_last_reg, out_last_next;

    // Zero-extended operand bits, summed below into popcount + carry.
    logic [CW:0] ext [N_OPS];
    logic [CW:0] total;
    logic        accept;

    genvar gi;
    generate
        for (gi = 0; gi < N_OPS; gi++) begin : g_ext
            assign ext[gi] = {{CW{1'b0}}, in_bits[gi]};
        end
    endgenerate

    always_comb begin
        total = (CW+1)'(carry_reg);
        for (int k = 0; k < N_OPS; k++) begin
            total = total + ext[k];
        end
    end

    assign in_ready = (st_reg == ST_ACCUM);
    assign accept   = in_valid & in_ready;

    always_comb begin
        st_next        = st_reg;
        carry_next     = carry_reg;
        cnt_next       = cnt_reg;
        out_valid_next = 1'b0;
        out_bit_next   = out_bit_reg;
        out_last_next  = 1'b0;
        if (clear) begin
            // Abort: drop the in-flight word and any slice offered this cycle.
            st_next    = ST_ACCUM;
            carry_next = '0;
            cnt_next   = '0;
        end else if (st_reg == ST_ACCUM) begin
            if (accept) begin
                out_bit_next   = total[0];
                carry_next     = total[CW:1];
                out_valid_next = 1'b1;
                if (cnt_reg == CNTW'(WORD_BITS-1)) begin
                    cnt_next = '0;
                    st_next  = ST_FLUSH;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
        end else begin
            out_bit_next   = carry_reg[0];
            carry_next     = carry_reg >> 1;
            out_valid_next = 1'b1;
            if (cnt_reg == CNTW'(CW-1)) begin
                out_last_next = 1'b1;
                st_next       = ST_ACCUM;
                cnt_next      = '0;
                carry_next    = '0;
            end else begin
                cnt_next = cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            st_reg        <= ST_ACCUM;
            carry_reg     <= '0;
            cnt_reg       <= '0;
            out_valid_reg <= 1'b0;
            out_bit_reg   <= 1'b0;
            out_last_reg  <= 1'b0;
        end else begin
            st_reg        <= st_next;
            carry_reg     <= carry_next;
            cnt_reg       <= cnt_next;
            out_valid_reg <= out_valid_next;
            out_bit_reg   <= out_bit_next;
            out_last_reg  <= out_last_next;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_bit   = out_bit_reg;
    assign out_last  = out_last_reg;
    assign busy      = (st_reg == ST_FLUSH) || (cnt_reg != '0);

endmodule

// File: tb/tb_serial_multi_adder.sv
// Self-checking bench: word sums from plain integer addition, compared bit by bit
// against the serial output of a 4-operand and a 3-operand instance.
module tb_serial_multi_adder;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       clear = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_bits = '0;
    logic       out_valid, out_bit, out_last, busy;

    logic       clear3 = 1'b0;
    logic       in_valid3 = 1'b0;
    logic       in_ready3;
    logic [2:0] in_bits3 = '0;
    logic       out_valid3, out_bit3, out_last3, busy3;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    serial_multi_adder #(.N_OPS(4), .WORD_BITS(8)) dut (
        .clock(clock), .reset(reset), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_bits(in_bits),
        .out_valid(out_valid), .out_bit(out_bit), .out_last(out_last), .busy(busy)
    );

    serial_multi_adder #(.N_OPS(3), .WORD_BITS(8)) dut3 (
        .clock(clock), .reset(reset), .clear(clear3),
        .in_valid(in_valid3), .in_ready(in_ready3), .in_bits(in_bits3),
        .out_valid(out_valid3), .out_bit(out_bit3), .out_last(out_last3), .busy(busy3)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Feeds one word (stall_pct = chance of an idle cycle) and checks every result bit.
    task automatic run_word(input logic [3:0][7:0] ops, input int stall_pct, input string name);
        int sum;
        int i;
        int guard;
        logic acc;
        logic [9:0] got;
        sum = int'(ops[0]) + int'(ops[1]) + int'(ops[2]) + int'(ops[3]);
        i = 0;
        guard = 0;
        got = '0;
        while (i < 8 && guard < 400) begin
            guard++;
            in_valid = ($urandom_range(0, 99) >= stall_pct);
            for (int k = 0; k < 4; k++) in_bits[k] = ops[k][i];
            acc = in_valid && in_ready;
            tests++;
            if (in_ready !== 1'b1) begin
                fails++;
                $display("FAIL %s in_ready_accum: got %b want 1", name, in_ready);
            end
            tick();
            tests++;
            if (acc) begin
                if (out_valid !== 1'b1 || out_bit !== sum[i] || out_last !== 1'b0) begin
                    fails++;
                    $display("FAIL %s bit%0d: got v=%b b=%b l=%b want v=1 b=%b l=0",
                             name, i, out_valid, out_bit, out_last, sum[i]);
                end
                got[i] = out_bit;
                i++;
            end else if (out_valid !== 1'b0) begin
                fails++;
                $display("FAIL %s stall_valid: got %b want 0", name, out_valid);
            end
        end
        if (guard >= 400) begin
            fails++;
            $display("FAIL %s accept_timeout: got %0d accepts want 8", name, i);
        end
        in_valid = 1'b0;
        for (int j = 0; j < 2; j++) begin
            tests++;
            if (in_ready !== 1'b0 || busy !== 1'b1) begin
                fails++;
                $display("FAIL %s flush_ready: got rdy=%b busy=%b want rdy=0 busy=1", name, in_ready, busy);
            end
            tick();
            tests++;
            if (out_valid !== 1'b1 || out_bit !== sum[8+j] || out_last !== (j == 1)) begin
                fails++;
                $display("FAIL %s flush%0d: got v=%b b=%b l=%b want v=1 b=%b l=%b",
                         name, j, out_valid, out_bit, out_last, sum[8+j], (j == 1));
            end
            got[8+j] = out_bit;
        end
        tests++;
        if (got !== sum[9:0] || in_ready !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL %s word: got 0x%03h rdy=%b busy=%b want 0x%03h rdy=1 busy=0",
                     name, got, in_ready, busy, sum[9:0]);
        end
        $display("[TB] %s: ops %02h %02h %02h %02h -> 0x%03h (expected 0x%03h)",
                 name, ops[0], ops[1], ops[2], ops[3], got, sum[9:0]);
    endtask

    // Accepts n slices of a word without checking result bits.
    task automatic push_slices(input logic [3:0][7:0] ops, input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            for (int k = 0; k < 4; k++) in_bits[k] = ops[k][i];
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        tests++;
        if (out_valid !== 1'b0 || out_bit !== 1'b0 || out_last !== 1'b0 ||
            in_ready !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: got v=%b b=%b l=%b rdy=%b busy=%b want 0 0 0 1 0",
                     out_valid, out_bit, out_last, in_ready, busy);
        end
        reset = 1'b0;
        $display("[TB] reset: outputs idle, in_ready=%b", in_ready);
    endtask

    task automatic test_basic();
        run_word({8'hFF, 8'hFF, 8'hFF, 8'hFF}, 0, "all_ff");
        run_word({8'h04, 8'h03, 8'h02, 8'h01}, 0, "ops_1234");
    endtask

    task automatic test_stall();
        run_word({8'hFF, 8'hFF, 8'hFF, 8'hFF}, 30, "all_ff_stall");
    endtask

    task automatic test_back_to_back();
        run_word({8'hFF, 8'hFF, 8'hFF, 8'hFF}, 0, "b2b_first");
        run_word({8'h04, 8'h03, 8'h02, 8'h01}, 0, "b2b_second");
    endtask

    task automatic test_clear();
        push_slices({8'hFF, 8'hFF, 8'hFF, 8'hFF}, 5);
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL clear_busy_mid: got %b want 1", busy);
        end
        clear = 1'b1;
        in_valid = 1'b1;
        in_bits = 4'hF;
        tick();
        clear = 1'b0;
        in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL clear_state: got v=%b l=%b busy=%b rdy=%b want 0 0 0 1",
                     out_valid, out_last, busy, in_ready);
        end
        $display("[TB] clear: word aborted after 5 slices");
        run_word({8'h04, 8'h03, 8'h02, 8'h01}, 0, "after_clear");
    endtask

    task automatic test_reset_flush();
        push_slices({8'hFF, 8'hFF, 8'hFF, 8'hFF}, 8);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_flush_state: got v=%b l=%b busy=%b rdy=%b want 0 0 0 1",
                     out_valid, out_last, busy, in_ready);
        end
        $display("[TB] reset during flush: state cleared");
        run_word({8'h04, 8'h03, 8'h02, 8'h01}, 0, "after_reset");
    endtask

    task automatic test_random();
        logic [3:0][7:0] ops;
        for (int w = 0; w < 12; w++) begin
            for (int k = 0; k < 4; k++) ops[k] = 8'($urandom_range(0, 255));
            run_word(ops, (w % 3) * 20, "random");
        end
    endtask

    task automatic test_n3();
        int sum;
        logic [9:0] got;
        sum = 3 * 255;
        got = '0;
        for (int i = 0; i < 10; i++) begin
            in_valid3 = (i < 8);
            in_bits3 = (i < 8) ? 3'b111 : 3'b000;
            tick();
            tests++;
            if (out_valid3 !== 1'b1 || out_bit3 !== sum[i] || out_last3 !== (i == 9)) begin
                fails++;
                $display("FAIL n3_bit%0d: got v=%b b=%b l=%b want v=1 b=%b l=%b",
                         i, out_valid3, out_bit3, out_last3, sum[i], (i == 9));
            end
            got[i] = out_bit3;
        end
        in_valid3 = 1'b0;
        tests++;
        if (got !== 10'h2FD) begin
            fails++;
            $display("FAIL n3_word: got 0x%03h want 0x2FD", got);
        end
        $display("[TB] n3: ff ff ff -> 0x%03h (expected 0x2fd)", got);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_back_to_back();
        test_clear();
        test_reset_flush();
        test_random();
        test_n3();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
